ball_ctrl: RTL and testbench

//  Moves the square (ball) for the breakout game: serve, wall/paddle bounce, loss detection, lives.

---
 rtl/ball_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_ball_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ball_ctrl.sv
// ball_ctrl: moves the breakout ball (serve, wall/paddle bounce, loss, lives).
// Ports:
//   i_clk, i_rst_n (async, active low)
//   i_ani_stb/i_animate  movement strobe and enable
//   i_mode  0 = hold game in reset/IDLE, 1 = play
//   i_start serve request
//   i_px1/i_px2  paddle left/right edges
//   i_hit_block  OR-ed block hit code (01 flip Y, 10 flip X, 11 both)
//   o_col_detected  hit acknowledge back to the blocks
//   o_x/o_y  ball centre; o_x1/o_x2/o_y1/o_y2 ball edges
//   o_lives, o_lost (pulse while in LOST), o_game_over
module ball_ctrl #(
    parameter int S_SIZE   = 5,
    parameter int SPEED    = 1,
    parameter int D_WIDTH  = 640,
    parameter int D_HEIGHT = 480,
    parameter int P_TOP    = 460,
    parameter int LIVES    = 3
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_ani_stb,
    input  logic        i_animate,
    input  logic        i_mode,
    input  logic        i_start,
    input  logic [11:0] i_px1,
    input  logic [11:0] i_px2,
    input  logic [1:0]  i_hit_block,
    output logic        o_col_detected,
    output logic [11:0] o_x,
    output logic [11:0] o_y,
    output logic [11:0] o_x1,
    output logic [11:0] o_x2,
    output logic [11:0] o_y1,
    output logic [11:0] o_y2,
    output logic [2:0]  o_lives,
    output logic        o_lost,
    output logic        o_game_over
);
    typedef enum logic [1:0] {IDLE, PLAY, LOST, GAMEOVER} state_t;

    localparam logic [12:0] SS     = 13'(S_SIZE);
    localparam logic [12:0] SP     = 13'(SPEED);
    localparam logic [12:0] X_MIN  = 13'(S_SIZE);
    localparam logic [12:0] X_MAX  = 13'(D_WIDTH - 1 - S_SIZE);
    localparam logic [12:0] Y_MIN  = 13'(S_SIZE);
    localparam logic [12:0] Y_PAD  = 13'(P_TOP - S_SIZE);
    localparam logic [12:0] PTOP   = 13'(P_TOP);
    localparam logic [12:0] Y_LOSS = 13'(D_HEIGHT - 1);
    localparam logic [11:0] X_RST  = 12'(D_WIDTH / 2);
    localparam logic [11:0] Y_RST  = 12'(P_TOP - S_SIZE - 1);
    localparam logic [2:0]  L_RST  = 3'(LIVES);

    state_t      state, state_n;
    logic [11:0] x, y, x_n, y_n;
    logic        dx, dy, dx_n, dy_n;
    logic        col, col_n;
    logic [2:0]  lives, lives_n;

    logic [12:0] x13, y13, px1_13, px2_13, sum13;
    logic [12:0] xs, ys;
    logic        pad_ok, hit_new, ndx, ndy;

    assign x13    = {1'b0, x};
    assign y13    = {1'b0, y};
    assign px1_13 = {1'b0, i_px1};
    assign px2_13 = {1'b0, i_px2};
    assign sum13  = px1_13 + px2_13;

    // Ball overlaps the paddle horizontally (edges inclusive).
    assign pad_ok  = (px1_13 <= x13 + SS) && (x13 <= px2_13 + SS);
    // A hit flips direction only on its first cycle; the ack masks the rest.
    assign hit_new = (i_hit_block != 2'b00) && !col;
    assign ndx     = dx ^ (hit_new & i_hit_block[1]);
    assign ndy     = dy ^ (hit_new & i_hit_block[0]);

    function automatic logic x_wall(input logic [12:0] p, input logic d);
        return d ? (p >= X_MAX - SP) : (p <= X_MIN + SP);
    endfunction

    // Returns {new_dir, new_pos}: clamp and bounce at a wall, else move.
    function automatic logic [12:0] x_step(input logic [11:0] p, input logic d);
        if (x_wall({1'b0, p}, d))
            return {~d, d ? X_MAX[11:0] : X_MIN[11:0]};
        return {d, d ? p + SP[11:0] : p - SP[11:0]};
    endfunction

    function automatic logic y_wall(input logic [12:0] p, input logic d, input logic pad);
        return d ? (pad && (p + SS <= PTOP) && (p + SS + SP >= PTOP))
                 : (p <= Y_MIN + SP);
    endfunction

    function automatic logic [12:0] y_step(input logic [11:0] p, input logic d, input logic pad);
        if (y_wall({1'b0, p}, d, pad))
            return {~d, d ? Y_PAD[11:0] : Y_MIN[11:0]};
        return {d, d ? p + SP[11:0] : p - SP[11:0]};
    endfunction

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            x     <= X_RST;
            y     <= Y_RST;
            dx    <= 1'b1;
            dy    <= 1'b0;
            col   <= 1'b0;
            lives <= L_RST;
        end else begin
            state <= state_n;
            x     <= x_n;
            y     <= y_n;
            dx    <= dx_n;
            dy    <= dy_n;
            col   <= col_n;
            lives <= lives_n;
        end
    end

    always_comb begin
        state_n = state;
        x_n     = x;
        y_n     = y;
        dx_n    = dx;
        dy_n    = dy;
        col_n   = 1'b0;
        lives_n = lives;
        xs      = '0;
        ys      = '0;
        if (!i_mode) begin
            state_n = IDLE;
            x_n     = X_RST;
            y_n     = Y_RST;
            dx_n    = 1'b1;
            dy_n    = 1'b0;
            lives_n = L_RST;
        end else begin
            case (state)
                IDLE: begin
                    x_n  = sum13[12:1];
                    y_n  = Y_RST;
                    dx_n = 1'b1;
                    dy_n = 1'b0;
                    if (i_start) state_n = PLAY;
                end
                PLAY: begin
                    if (dy && (y13 + SS >= Y_LOSS)) begin
                        state_n = LOST;
                    end else begin
                        // Set on a new hit, held while the code stays, cleared when it drops.
                        col_n = (i_hit_block != 2'b00);
                        dx_n  = ndx;
                        dy_n  = ndy;
                        if (i_ani_stb && i_animate) begin
                            // A wall on the pre-hit direction overrides the hit flip.
                            xs = x_wall(x13, dx) ? x_step(x, dx) : x_step(x, ndx);
                            ys = y_wall(y13, dy, pad_ok) ? y_step(y, dy, pad_ok)
                                                         : y_step(y, ndy, pad_ok);
                            {dx_n, x_n} = xs;
                            {dy_n, y_n} = ys;
                        end
                    end
                end
                LOST: begin
                    lives_n = lives - 3'd1;
                    state_n = (lives == 3'd1) ? GAMEOVER : IDLE;
                end
                GAMEOVER: ;
                default: state_n = IDLE;
            endcase
        end
    end

    assign o_col_detected = col;
    assign o_x            = x;
    assign o_y            = y;
    assign o_x1           = x - SS[11:0];
    assign o_x2           = x + SS[11:0];
    assign o_y1           = y - SS[11:0];
    assign o_y2           = y + SS[11:0];
    assign o_lives        = lives;
    assign o_lost         = (state == LOST);
    assign o_game_over    = (state == GAMEOVER);
endmodule

// File: tb/tb_ball_ctrl.sv
// Bench for ball_ctrl with default parameters (S_SIZE=5, SPEED=1, 640x480,
// P_TOP=460, LIVES=3). A behavioural model predicts each cycle's outputs;
// predictions are queued when inputs are driven and compared after the edge.
module tb_ball_ctrl;
    localparam int S = 5, SP = 1, XR = 634, XL = 5, YT = 5, YP = 455, PT = 460, YL = 479;

    logic        clk, rst_n, stb, anim, mode, start;
    logic [11:0] px1, px2;
    logic [1:0]  hit;
    logic        o_col_detected, o_lost, o_game_over;
    logic [11:0] o_x, o_y, o_x1, o_x2, o_y1, o_y2;
    logic [2:0]  o_lives;

    ball_ctrl dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_ani_stb(stb), .i_animate(anim),
        .i_mode(mode), .i_start(start), .i_px1(px1), .i_px2(px2),
        .i_hit_block(hit), .o_col_detected(o_col_detected),
        .o_x(o_x), .o_y(o_y), .o_x1(o_x1), .o_x2(o_x2), .o_y1(o_y1), .o_y2(o_y2),
        .o_lives(o_lives), .o_lost(o_lost), .o_game_over(o_game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {int x; int y; int col; int lives; int lost; int go;} exp_t;
    exp_t sb[$];

    int n_cmp = 0, n_bad = 0;
    int m_st, m_x, m_y, m_dx, m_dy, m_col, m_lives;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_st = 0; m_x = 320; m_y = 454; m_dx = 1; m_dy = 0; m_col = 0; m_lives = 3;
    endtask

    function automatic bit xwall(int x, int d);
        int t = d ? x + SP : x - SP;
        return d ? (t >= XR) : (t <= XL);
    endfunction

    function automatic bit ywall(int y, int d, int pad);
        if (d == 0) return (y - SP) <= YT;
        return pad != 0 && (y + S <= PT) && (y + SP + S >= PT);
    endfunction

    task automatic model_step();
        int ndx, ndy, du, pad;
        if (!mode) begin m_reset(); return; end
        case (m_st)
            0: begin
                m_x = (int'(px1) + int'(px2)) / 2; m_y = 454; m_dx = 1; m_dy = 0; m_col = 0;
                if (start) m_st = 1;
            end
            1: begin
                if (m_dy == 1 && m_y + S >= YL) begin
                    m_st = 2; m_col = 0;
                end else begin
                    ndx = m_dx; ndy = m_dy;
                    if (hit != 2'b00 && m_col == 0) begin
                        ndx = ndx ^ int'(hit[1]); ndy = ndy ^ int'(hit[0]);
                    end
                    m_col = (hit != 2'b00) ? 1 : 0;
                    if (stb && anim) begin
                        pad = (int'(px1) <= m_x + S && m_x <= int'(px2) + S) ? 1 : 0;
                        du = xwall(m_x, m_dx) ? m_dx : ndx;
                        if (xwall(m_x, du)) begin m_x = du ? XR : XL; m_dx = 1 - du; end
                        else begin m_x = du ? m_x + SP : m_x - SP; m_dx = du; end
                        du = ywall(m_y, m_dy, pad) ? m_dy : ndy;
                        if (ywall(m_y, du, pad)) begin m_y = du ? YP : YT; m_dy = 1 - du; end
                        else begin m_y = du ? m_y + SP : m_y - SP; m_dy = du; end
                    end else begin
                        m_dx = ndx; m_dy = ndy;
                    end
                end
            end
            2: begin
                m_lives = m_lives - 1; m_st = (m_lives == 0) ? 3 : 0; m_col = 0;
            end
            default: m_col = 0;
        endcase
    endtask

    task automatic tick();
        exp_t e;
        model_step();
        e = '{m_x, m_y, m_col, m_lives, (m_st == 2) ? 1 : 0, (m_st == 3) ? 1 : 0};
        sb.push_back(e);
        @(posedge clk); #1;
        e = sb.pop_front();
        chk("x", o_x, e.x);
        chk("y", o_y, e.y);
        chk("x1", o_x1, e.x - S);
        chk("y2", o_y2, e.y + S);
        chk("col", o_col_detected, e.col);
        chk("lives", o_lives, e.lives);
        chk("lost", o_lost, e.lost);
        chk("game_over", o_game_over, e.go);
    endtask

    task automatic strobe();
        stb = 1'b1; tick(); stb = 1'b0; tick();
    endtask

    initial begin
        int n;
        rst_n = 1'b0; stb = 1'b0; anim = 1'b1; mode = 1'b1; start = 1'b0;
        px1 = 12'd290; px2 = 12'd350; hit = 2'b00;
        m_reset();
        #12;
        chk("rst_x", o_x, 320);   chk("rst_y", o_y, 454);
        chk("rst_x1", o_x1, 315); chk("rst_x2", o_x2, 325);
        chk("rst_y1", o_y1, 449); chk("rst_y2", o_y2, 459);
        chk("rst_lives", o_lives, 3); chk("rst_col", o_col_detected, 0);
        chk("rst_lost", o_lost, 0);   chk("rst_go", o_game_over, 0);
        rst_n = 1'b1;

        // Serve from the paddle centre, one masked strobe, then 10 moves.
        tick(); tick();
        chk("t1_idle_x", o_x, 320); chk("t1_idle_y", o_y, 454);
        start = 1'b1; tick(); start = 1'b0;
        anim = 1'b0; stb = 1'b1; tick(); stb = 1'b0; anim = 1'b1;
        chk("t1_anim_off_x", o_x, 320);
        for (int i = 0; i < 10; i++) strobe();
        chk("t1_x", o_x, 330); chk("t1_y", o_y, 444);

        // Y hit held three cycles: single flip, ack high until the code drops.
        hit = 2'b01;
        for (int i = 0; i < 3; i++) begin tick(); chk("t2_col_hi", o_col_detected, 1); end
        hit = 2'b00; tick(); chk("t2_col_lo", o_col_detected, 0);

        // Now descending; paddle under the ball bounces it at y=455.
        n = 0;
        while (!(m_y == 454 && m_dy == 1) && n < 50) begin strobe(); n++; end
        chk("t4_reach_timeout", (n < 50) ? 1 : 0, 1);
        px1 = 12'(m_x - 10); px2 = 12'(m_x + 50);
        strobe(); chk("t4_bounce_y", o_y, 455);
        strobe(); chk("t4_up_y", o_y, 454);

        // Flip X, run to the left wall, and hit X on the wall strobe.
        hit = 2'b10; tick(); hit = 2'b00; tick();
        n = 0;
        while (!(m_x == 6 && m_dx == 0) && n < 700) begin strobe(); n++; end
        chk("t3_reach_timeout", (n < 700) ? 1 : 0, 1);
        stb = 1'b1; hit = 2'b10; tick(); stb = 1'b0; hit = 2'b00;
        chk("t3_wall_x", o_x, 5); chk("t3_wall_col", o_col_detected, 1);
        tick(); strobe(); chk("t3_after_x", o_x, 6);

        // Asynchronous reset between strobes with an ack pending.
        hit = 2'b01; tick(); hit = 2'b00;
        chk("t6_col_pending", o_col_detected, 1);
        #2 rst_n = 1'b0; #1;
        m_reset();
        chk("t6_x", o_x, 320); chk("t6_y", o_y, 454);
        chk("t6_col", o_col_detected, 0); chk("t6_lives", o_lives, 3);
        #1 rst_n = 1'b1;

        // Lose all three balls with the paddle out of the way.
        for (int life = 0; life < 3; life++) begin
            px1 = 12'd290; px2 = 12'd350; start = 1'b1; tick(); start = 1'b0;
            px1 = 12'd400; px2 = 12'd460;
            hit = 2'b01; tick(); hit = 2'b00;
            strobe(); chk("t4_miss_y1", o_y, 455);
            strobe(); chk("t4_miss_y2", o_y, 456);
            n = 0;
            while (m_st != 2 && n < 200) begin stb = (n % 2 == 0); tick(); n++; end
            stb = 1'b0;
            chk("t5_loss_timeout", (n < 200) ? 1 : 0, 1);
            chk("t5_lost_pulse", o_lost, 1);
            tick();
            chk("t5_lost_clear", o_lost, 0);
            chk("t5_lives", o_lives, 2 - life);
        end
        chk("t5_game_over", o_game_over, 1);
        start = 1'b1; tick(); tick(); start = 1'b0;
        chk("t5_start_ignored", o_game_over, 1);
        mode = 1'b0; tick(); mode = 1'b1;
        chk("t5_mode_lives", o_lives, 3); chk("t5_mode_go", o_game_over, 0);

        // Random play scored by the model.
        for (int i = 0; i < 600; i++) begin
            stb   = ($urandom_range(0, 2) == 0);
            anim  = ($urandom_range(0, 7) != 0);
            hit   = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            start = ($urandom_range(0, 3) == 0);
            mode  = ($urandom_range(0, 199) != 0);
            px1   = 12'($urandom_range(0, 560));
            px2   = px1 + 12'($urandom_range(10, 70));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
